// File: rtl/riscv_mem_pkg.sv
// Shared types for the riscv memory arbiter: request owner and the
// in-flight response tag carried alongside the BRAM read latency.
package riscv_mem_pkg;

    typedef enum logic {
        MEM_OWNER_IMEM = 1'b0,
        MEM_OWNER_DMEM = 1'b1
    } mem_owner_t;

    typedef struct packed {
        logic       valid;
        mem_owner_t owner;
    } mem_tag_t;

    localparam mem_tag_t MEM_TAG_IDLE = '{valid: 1'b0, owner: MEM_OWNER_IMEM};

endpackage

// File: rtl/riscv_mem_tag_pipe.sv
// Fixed-depth shift register of response tags; the tail stage lines up
// with the cycle the BRAM presents read data for the tagged request.
module riscv_mem_tag_pipe
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_in,
    input  logic     rst_n_in,
    input  mem_tag_t tag_in,
    output mem_tag_t tag_out
);

    mem_tag_t stage_q [DEPTH];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= MEM_TAG_IDLE;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port BRAM between the fetch and load/store ports:
// dmem has priority, a streak counter guarantees fetch forward progress.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 14,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_DMEM_STREAK = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  imem_req_valid_in,
    output logic                  imem_req_ready_out,
    input  logic [31:0]           imem_addr_in,
    output logic                  imem_resp_valid_out,
    output logic [31:0]           imem_resp_data_out,
    input  logic                  dmem_req_valid_in,
    output logic                  dmem_req_ready_out,
    input  logic [31:0]           dmem_addr_in,
    input  logic [31:0]           dmem_data_in,
    input  logic [3:0]            dmem_write_enable_in,
    output logic                  dmem_resp_valid_out,
    output logic [31:0]           dmem_resp_data_out,
    output logic                  mem_enable_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [31:0]           mem_data_out,
    output logic [3:0]            mem_write_enable_out,
    input  logic [31:0]           mem_data_in
);

    localparam int STREAK_W = (MAX_DMEM_STREAK < 1) ? 1 : $clog2(MAX_DMEM_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DMEM_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                guard_hit;
    logic                dmem_grant;
    logic                imem_grant;
    mem_tag_t            tag_in;
    mem_tag_t            tag_tail;
    logic                unused_addr_bits;

    // Grants are qualified by reset so nothing is accepted while rst_n_in is low.
    assign guard_hit  = (MAX_DMEM_STREAK != 0) && (streak_q == STREAK_MAX) && imem_req_valid_in;
    assign dmem_grant = rst_n_in && dmem_req_valid_in && !guard_hit;
    assign imem_grant = rst_n_in && imem_req_valid_in && !dmem_grant;

    assign dmem_req_ready_out = dmem_grant;
    assign imem_req_ready_out = imem_grant;

    always_comb begin
        streak_d = streak_q;
        if (!imem_req_valid_in || imem_grant) begin
            streak_d = '0;
        end else if (dmem_grant && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    always_comb begin
        mem_enable_out       = 1'b0;
        mem_addr_out         = '0;
        mem_data_out         = '0;
        mem_write_enable_out = '0;
        if (dmem_grant) begin
            mem_enable_out       = 1'b1;
            mem_addr_out         = dmem_addr_in[ADDR_WIDTH+1:2];
            mem_data_out         = dmem_data_in;
            mem_write_enable_out = dmem_write_enable_in;
        end else if (imem_grant) begin
            mem_enable_out       = 1'b1;
            mem_addr_out         = imem_addr_in[ADDR_WIDTH+1:2];
        end
    end

    assign tag_in = '{valid: (dmem_grant || imem_grant),
                      owner: (dmem_grant ? MEM_OWNER_DMEM : MEM_OWNER_IMEM)};

    riscv_mem_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .tag_in   (tag_in),
        .tag_out  (tag_tail)
    );

    // Data is unqualified on both ports; only the valid selects the owner.
    assign imem_resp_valid_out = tag_tail.valid && (tag_tail.owner == MEM_OWNER_IMEM);
    assign dmem_resp_valid_out = tag_tail.valid && (tag_tail.owner == MEM_OWNER_DMEM);
    assign imem_resp_data_out  = mem_data_in;
    assign dmem_resp_data_out  = mem_data_in;

    assign unused_addr_bits = ^{imem_addr_in[31:ADDR_WIDTH+2], imem_addr_in[1:0],
                                dmem_addr_in[31:ADDR_WIDTH+2], dmem_addr_in[1:0]};

endmodule
